// File: rtl/serial_addsub_pkg.sv
// Shared types and elaboration helpers for the bit-serial adder/subtractor.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 64;

  // Bit-index width; never below one bit so the index port always exists.
  function automatic int idx_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit combinational full adder used as the single arithmetic cell.
module serial_fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor, LSB first, one bit per clock.
// Define SERIAL_ADDSUB_OVF_EN to add the registered signed-overflow output ovf.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int IDX_W = idx_width(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic [IDX_W-1:0] i,
  output logic             c_out
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
    $error("serial_addsub: WIDTH must be within 2..64");
  end

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic             fa_sum;
  logic             fa_cout;

  serial_fa_cell u_fa (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Sum bits re-enter the A register from the MSB, so after WIDTH shifts it holds the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      i     <= '0;
      c_out <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub ? ~c_in : c_in;
            i     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sr  <= {fa_sum, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          carry <= fa_cout;
          if (i == LAST_IDX) begin
            s     <= {fa_sum, a_sr[WIDTH-1:1]};
            c_out <= fa_cout;
`ifdef SERIAL_ADDSUB_OVF_EN
            // carry here is the carry into the MSB; fa_cout is the carry out of it.
            ovf   <= carry ^ fa_cout;
`endif
            i     <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            i <= i + IDX_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub: randomized and directed operations against an arithmetic model.
module tb_serial_addsub;

  localparam int W  = 4;
  localparam int IW = (W <= 2) ? 1 : $clog2(W);

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          sub   = 1'b0;
  logic          c_in  = 1'b0;
  logic [W-1:0]  a     = '0;
  logic [W-1:0]  b     = '0;
  logic          busy;
  logic          done;
  logic          c_out;
  logic [W-1:0]  s;
  logic [IW-1:0] i;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic          ovf;
`endif

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    int           acc;
  } exp_t;

  exp_t         q[$];
  int           checks = 0;
  int           errors = 0;
  int           cyc    = 0;
  logic [W-1:0] hold_s = '0;
  logic         hold_c = 1'b0;
  logic         hold_v = 1'b0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .i     (i),
    .c_out (c_out)
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain integer arithmetic: unsigned result/carry and signed range test for overflow.
  function automatic exp_t model(input int av, input int bv, input int cv, input int sv, input int acc);
    exp_t e;
    int   r, sa, sb, sr;
    r     = sv ? (av - bv - cv) : (av + bv + cv);
    e.s   = W'(r);
    e.c   = sv ? (r >= 0) : (r >= (1 << W));
    sa    = (av >= (1 << (W - 1))) ? av - (1 << W) : av;
    sb    = (bv >= (1 << (W - 1))) ? bv - (1 << W) : bv;
    sr    = sv ? (sa - sb - cv) : (sa + sb + cv);
    e.v   = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
    e.acc = acc;
    return e;
  endfunction

  task automatic applyStimulus(input int av, input int bv, input int cv, input int sv, output int acc);
    int n;
    n   = 0;
    acc = -1;
    @(negedge clk);
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      checkOutput("accept_timeout", 64'(busy), 64'(0));
      return;
    end
    a     = W'(av);
    b     = W'(bv);
    c_in  = cv[0];
    sub   = sv[0];
    start = 1'b1;
    acc   = cyc + 1;
    q.push_back(model(av, bv, cv, sv, acc));
  endtask

  task automatic idleCycles(input int n);
    @(negedge clk);
    start = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  // Monitor: samples just after each rising edge and retires expectations on done.
  initial begin
    exp_t e;
    logic exp_busy;
    int   exp_i;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        q.delete();
        hold_s = '0;
        hold_c = 1'b0;
        hold_v = 1'b0;
        checkOutput("reset_busy", 64'(busy), 64'(0));
        checkOutput("reset_done", 64'(done), 64'(0));
        checkOutput("reset_s", 64'(s), 64'(0));
        checkOutput("reset_i", 64'(i), 64'(0));
        checkOutput("reset_c_out", 64'(c_out), 64'(0));
      end else if (done === 1'b1) begin
        if (q.size() == 0) begin
          checkOutput("spurious_done", 64'(done), 64'(0));
        end else begin
          e = q.pop_front();
          checkOutput("done_latency", 64'(cyc), 64'(e.acc + W));
          checkOutput("result_s", 64'(s), 64'(e.s));
          checkOutput("result_c_out", 64'(c_out), 64'(e.c));
`ifdef SERIAL_ADDSUB_OVF_EN
          checkOutput("result_ovf", 64'(ovf), 64'(e.v));
`endif
          hold_s = e.s;
          hold_c = e.c;
          hold_v = e.v;
        end
        checkOutput("busy_at_done", 64'(busy), 64'(0));
        checkOutput("i_at_done", 64'(i), 64'(0));
      end else begin
        if (q.size() > 0 && cyc >= q[0].acc + W) begin
          checkOutput("done_missing", 64'(done), 64'(1));
          void'(q.pop_front());
        end
        exp_busy = (q.size() > 0) && (cyc >= q[0].acc) && (cyc < q[0].acc + W);
        exp_i    = exp_busy ? cyc - q[0].acc : 0;
        checkOutput("busy", 64'(busy), 64'(exp_busy));
        checkOutput("index_i", 64'(i), 64'(exp_i));
        checkOutput("s_hold", 64'(s), 64'(hold_s));
        checkOutput("c_out_hold", 64'(c_out), 64'(hold_c));
`ifdef SERIAL_ADDSUB_OVF_EN
        checkOutput("ovf_hold", 64'(ovf), 64'(hold_v));
`endif
      end
    end
  end

  initial begin
    int acc, prev_acc, n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("post_reset_s", 64'(s), 64'(0));
    checkOutput("post_reset_busy", 64'(busy), 64'(0));

    // Directed add/sub cases, each followed by idle time.
    applyStimulus(5, 3, 0, 0, acc);   idleCycles(6);
    applyStimulus(15, 1, 0, 0, acc);  idleCycles(6);
    applyStimulus(15, 15, 1, 0, acc); idleCycles(6);
    applyStimulus(5, 7, 0, 1, acc);   idleCycles(6);
    applyStimulus(9, 4, 1, 1, acc);   idleCycles(6);
    applyStimulus(7, 1, 0, 0, acc);   idleCycles(6);
    applyStimulus(8, 1, 0, 1, acc);   idleCycles(6);

    // A start raised mid-operation with other operands must be ignored.
    applyStimulus(6, 2, 0, 0, acc);
    idleCycles(2);
    a = W'(1); b = W'(1); sub = 1'b1; c_in = 1'b1; start = 1'b1;
    idleCycles(6);

    // Reset in the middle of an operation aborts it without a done pulse.
    applyStimulus(9, 9, 0, 0, acc);
    idleCycles(2);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checkOutput("abort_s", 64'(s), 64'(0));
    checkOutput("abort_busy", 64'(busy), 64'(0));
    applyStimulus(3, 4, 0, 0, acc);   idleCycles(6);

    // Start held high: one result every W+1 cycles.
    prev_acc = -1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(int'($urandom_range(2**W - 1, 0)), int'($urandom_range(2**W - 1, 0)),
                    int'($urandom_range(1, 0)), int'($urandom_range(1, 0)), acc);
      if (k > 0) checkOutput("b2b_spacing", 64'(acc - prev_acc), 64'(W + 1));
      prev_acc = acc;
    end
    idleCycles(6);

    // Exhaustive operand sweep with random mode and carry, issued back-to-back.
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        applyStimulus(av, bv, int'($urandom_range(1, 0)), int'($urandom_range(1, 0)), acc);
      end
    end
    idleCycles(3);

    // Random operations with random gaps.
    for (int k = 0; k < 60; k++) begin
      applyStimulus(int'($urandom_range(2**W - 1, 0)), int'($urandom_range(2**W - 1, 0)),
                    int'($urandom_range(1, 0)), int'($urandom_range(1, 0)), acc);
      if ($urandom_range(1, 0) == 1) idleCycles(int'($urandom_range(8, 1)));
    end
    idleCycles(1);

    n = 0;
    while (q.size() > 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 64'(q.size()), 64'(0));
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised bit-serial adder/subtractor; next generation of the team's 4-bit serial adder.
- Generalised to WIDTH bits, with add/subtract mode, a start/busy/done handshake, explicit reset, and a registered result.
- Processes one bit per clock, LSB first, through a single full-adder cell.
- Sits as a low-area arithmetic unit beside control logic that tolerates WIDTH-cycle latency.

Parameters:
- WIDTH, 4, operand/result width in bits; legal range 2..64.
- IDX_W, max(1,$clog2(WIDTH)), width of bit-index output; derived, not overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0=add, 1=subtract; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- c_in  input  1  carry-in (add) / borrow-in (sub); captured with start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse when s/c_out become valid.
- s  output  WIDTH  registered result; holds until next completion.
- i  output  IDX_W  index of the bit processed on the next edge; 0 when not busy.
- c_out  output  1  final carry; in sub mode 1 = no borrow.
- ovf  output  1  signed overflow; only with SERIAL_ADDSUB_OVF_EN.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, s=0, i=0, c_out=0, ovf=0; internal shift registers and carry = 0. A reset mid-operation aborts the operation with no done pulse. After deassertion the block starts in IDLE.
- States:
  - IDLE: waits for start.
  - RUN: processes bits.
  - DONE: single cycle, done=1.
- IDLE/DONE with start=1 at edge E0:
  - Load A shift register with a.
  - Load B shift register with sub ? ~b : b.
  - Load carry with sub ? ~c_in : c_in.
  - Go to RUN with i=0, busy=1.
  - Add mode computes a+b+c_in. Sub mode computes a-b-c_in as a+~b+~c_in.
- RUN, each edge:
  - sum bit = A[0]^B[0]^carry, shifted into the result shift register from the MSB side.
  - carry = majority(A[0],B[0],carry); A and B shift right.
  - i increments.
- When the bit with i=WIDTH-1 is processed (edge E_WIDTH):
  - s is loaded with the full result and c_out with the final carry.
  - State goes to DONE; busy=0; i=0.
- DONE lasts exactly one cycle; done=1 there. Next state is RUN if start=1 (back-to-back operation, new operands captured), otherwise IDLE.
- Latency: start accepted at E0; done high during the cycle after E_WIDTH (WIDTH cycles). Throughput: one result per WIDTH+1 cycles with start held high.
- start while busy=1: ignored; operands and the in-flight operation are unaffected.
- s, c_out and ovf change only at completion; they stay stable through IDLE and the next RUN.
- All arithmetic is modulo 2^WIDTH; no saturation.

Optional Feature:
- SERIAL_ADDSUB_OVF_EN defined:
  - ovf port exists.
  - At completion, ovf = carry into the MSB XOR carry out of the MSB, i.e. two's-complement overflow of the effective operation.
  - ovf is registered with s and reset to 0.
- Not defined: ovf port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package serial_addsub_pkg:
  - state typedef (IDLE, RUN, DONE; 2-bit encoding).
  - function computing IDX_W from WIDTH.
  - WIDTH bounds constants for elaboration checks.
- One sub-module, serial_fa_cell: combinational 1-bit full adder (a, b, cin -> sum, cout), instantiated once.
- Control FSM, shift registers and carry flop stay in the top module.

Test Plan:
- WIDTH=4, add a=5 b=3 c_in=0, start one cycle: i steps 0,1,2,3; done pulses exactly 4 cycles after start edge; s=8, c_out=0.
- WIDTH=4, add a=15 b=1 c_in=0: s=0, c_out=1; then a=15 b=15 c_in=1: s=15, c_out=1.
- WIDTH=4, sub=1 a=5 b=7 c_in=0: s=14, c_out=0 (borrow); then sub a=9 b=4 c_in=1: s=4, c_out=1.
- start pulsed at cycle 2 of a RUN with different operands: ignored; original result appears; s/c_out unchanged until that done.
- rst_n low mid-RUN: busy=0, done never pulses, s=0. Following start of 3+4 gives s=7 after 4 cycles. Also start held high gives back-to-back results every 5 cycles.
- WIDTH=8, SERIAL_ADDSUB_OVF_EN: add 127+1 -> s=128, ovf=1; sub 0x80-1 -> s=127, ovf=1; 100+27 -> ovf=0. Exhaustive 16x16 sweep at WIDTH=4 against a reference model.
